// File: rtl/gerador_jogo.sv
// gerador_jogo: draws one werewolf and one seer position among 5 players and
// packs them into the 10-bit game word (2 bits per player, player 0 in [1:0]).
// Class codes: 00 villager, 01 werewolf, 10 seer, 11 never produced.
//
// Handshake: gera is a request that is only looked at while the block is in
// IDLE (ocupado=0); a request seen in any other state is dropped, never
// queued. Each accepted request produces exactly one single-cycle pronto pulse
// 4 to 10 cycles later, and jogo already holds the new word in that cycle and
// keeps it until the next word is assembled. rst_global aborts a draw with no
// pronto.
module gerador_jogo #(
  parameter logic [7:0] SEMENTE = 8'hB4
) (
  input  logic       clock,
  input  logic       rst_global,
  input  logic       gera,
  input  logic       entropia,
  output logic [9:0] jogo,
  output logic       pronto,
  output logic       ocupado,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    IDLE            = 3'd0,
    SORTEIA_LOBO    = 3'd1,
    SORTEIA_VIDENTE = 3'd2,
    MONTA           = 3'd3,
    PRONTO          = 3'd4
  } estado_t;

  localparam logic [2:0] NUM_JOGADORES = 3'd5;

  estado_t    r_estado;
  estado_t    w_prox_estado;

  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_desloc;
  logic [7:0] w_lfsr_prox;
  logic       w_fb;

  logic [2:0] r_lobo;
  logic [2:0] r_vidente;
  logic [1:0] r_tent;
  logic [9:0] r_jogo;

  logic [2:0] w_lobo_prox;
  logic [2:0] w_vidente_prox;
  logic [1:0] w_tent_prox;
  logic [9:0] w_jogo_prox;

  logic [2:0] w_cand;
  logic       w_cand_menor5;
  logic [2:0] w_cand_dobrado;
  logic [2:0] w_lobo_mais1;
  logic [2:0] w_vid_dobrado;
  logic       w_vid_valido;
  logic       w_tent_esgotada;
  logic [9:0] w_palavra;

  // LFSR next value: user entropy folded into the feedback, all-zero lock-up avoided.
  always_comb begin
    w_fb          = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3] ^ entropia;
    w_lfsr_desloc = {r_lfsr[6:0], w_fb};
    w_lfsr_prox   = (w_lfsr_desloc == 8'h00) ? 8'h01 : w_lfsr_desloc;
  end

  // Candidate position and the fold values used when the attempts run out.
  always_comb begin
    w_cand          = r_lfsr[2:0];
    w_cand_menor5   = (w_cand < NUM_JOGADORES);
    w_cand_dobrado  = w_cand_menor5 ? w_cand : (w_cand - NUM_JOGADORES);
    w_lobo_mais1    = (r_lobo == 3'd4) ? 3'd0 : (r_lobo + 3'd1);
    w_vid_dobrado   = (w_cand_dobrado == r_lobo) ? w_lobo_mais1 : w_cand_dobrado;
    w_vid_valido    = w_cand_menor5 && (w_cand != r_lobo);
    w_tent_esgotada = (r_tent == 2'd3);
  end

  // Packed game word built from the two registered positions.
  always_comb begin
    w_palavra = 10'h000;
    for (int i = 0; i < 5; i++) begin
      if (r_lobo == 3'(i)) begin
        w_palavra[2*i +: 2] = 2'b01;
      end else if (r_vidente == 3'(i)) begin
        w_palavra[2*i +: 2] = 2'b10;
      end
    end
  end

  // Next-state and datapath update for the draw sequence.
  always_comb begin
    w_prox_estado  = r_estado;
    w_lobo_prox    = r_lobo;
    w_vidente_prox = r_vidente;
    w_tent_prox    = r_tent;
    w_jogo_prox    = r_jogo;
    case (r_estado)
      IDLE: begin
        if (gera) begin
          w_prox_estado = SORTEIA_LOBO;
          w_tent_prox   = 2'd0;
        end
      end
      SORTEIA_LOBO: begin
        if (w_cand_menor5) begin
          w_lobo_prox   = w_cand;
          w_tent_prox   = 2'd0;
          w_prox_estado = SORTEIA_VIDENTE;
        end else if (w_tent_esgotada) begin
          // Only reached with a candidate of 5..7, so this maps it onto 0..2.
          w_lobo_prox   = w_cand_dobrado;
          w_tent_prox   = 2'd0;
          w_prox_estado = SORTEIA_VIDENTE;
        end else begin
          w_tent_prox = r_tent + 2'd1;
        end
      end
      SORTEIA_VIDENTE: begin
        if (w_vid_valido) begin
          w_vidente_prox = w_cand;
          w_prox_estado  = MONTA;
        end else if (w_tent_esgotada) begin
          // Forced result so the draw always ends within four attempts.
          w_vidente_prox = w_vid_dobrado;
          w_prox_estado  = MONTA;
        end else begin
          w_tent_prox = r_tent + 2'd1;
        end
      end
      MONTA: begin
        w_jogo_prox   = w_palavra;
        w_prox_estado = PRONTO;
      end
      PRONTO: begin
        w_prox_estado = IDLE;
      end
      default: begin
        w_prox_estado = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset wins over everything.
  always_ff @(posedge clock) begin
    if (rst_global) begin
      r_estado  <= IDLE;
      r_lfsr    <= SEMENTE;
      r_lobo    <= 3'd0;
      r_vidente <= 3'd0;
      r_tent    <= 2'd0;
      r_jogo    <= 10'h000;
    end else begin
      r_estado  <= w_prox_estado;
      r_lfsr    <= w_lfsr_prox;
      r_lobo    <= w_lobo_prox;
      r_vidente <= w_vidente_prox;
      r_tent    <= w_tent_prox;
      r_jogo    <= w_jogo_prox;
    end
  end

  assign jogo      = r_jogo;
  assign pronto    = (r_estado == PRONTO);
  assign ocupado   = (r_estado != IDLE);
  assign db_estado = r_estado;

endmodule

// File: tb/tb_gerador_jogo.sv
// Testbench for gerador_jogo: directed draws from the known seed, busy and
// reset-abort cases, a randomised sweep and forced fold paths, all checked
// against a behavioural draw model through an expected-word queue.
module tb_gerador_jogo;

  localparam logic [7:0] SEED = 8'hB4;

  logic       clock = 1'b0;
  logic       rst_global;
  logic       gera;
  logic       entropia;
  logic [9:0] jogo;
  logic       pronto;
  logic       ocupado;
  logic [2:0] db_estado;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_pronto = 0;

  // {issue cycle[41:26], pronto cycle[25:10], word[9:0]}
  logic [41:0] exp_q[$];
  logic [7:0]  m_lfsr;
  bit          seen_lobo[5];

  gerador_jogo #(.SEMENTE(SEED)) dut (
    .clock     (clock),
    .rst_global(rst_global),
    .gera      (gera),
    .entropia  (entropia),
    .jogo      (jogo),
    .pronto    (pronto),
    .ocupado   (ocupado),
    .db_estado (db_estado)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] lfsr_step(input logic [7:0] l, input logic e);
    logic [7:0] n;
    n = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3] ^ e};
    if (n == 8'h00) n = 8'h01;
    return n;
  endfunction

  // l0 is the LFSR in the cycle gera is sampled; ent[k] is entropia in cycle k after it.
  function automatic void model_draw(input logic [7:0] l0, input logic [15:0] ent,
                                     output logic [9:0] word, output int lat, output int lobo,
                                     output int nl, output int nv, output bit lf, output bit vf);
    logic [7:0] l;
    int k, c, v, vid;
    bit done;
    l = l0; k = 0; lobo = 0; vid = 0; nl = 0; nv = 0; lf = 1'b0; vf = 1'b0;
    done = 1'b0;
    for (int a = 0; a < 4; a++) begin
      if (!done) begin
        l = lfsr_step(l, ent[k]); k++; nl++;
        c = int'(l[2:0]);
        if (c < 5) begin lobo = c; done = 1'b1; end
        else if (a == 3) begin lobo = c - 5; lf = 1'b1; done = 1'b1; end
      end
    end
    done = 1'b0;
    for (int a = 0; a < 4; a++) begin
      if (!done) begin
        l = lfsr_step(l, ent[k]); k++; nv++;
        c = int'(l[2:0]);
        if (c < 5 && c != lobo) begin vid = c; done = 1'b1; end
        else if (a == 3) begin
          v = (c >= 5) ? c - 5 : c;
          vid = (v == lobo) ? (lobo + 1) % 5 : v;
          vf = 1'b1; done = 1'b1;
        end
      end
    end
    lat = k + 2;
    word = 10'h000;
    word[2*lobo +: 2] = 2'b01;
    word[2*vid +: 2]  = 2'b10;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at the start of a cycle; checks state/pronto at negedge when asked.
  task automatic step(input logic g, input logic e, input int exp_db, input int exp_p);
    gera = g; entropia = e;
    @(negedge clock);
    if (exp_db >= 0) begin
      check("db_estado", 32'(db_estado), 32'(exp_db));
      check("ocupado", 32'(ocupado), (exp_db != 0) ? 32'd1 : 32'd0);
    end
    if (exp_p >= 0) check("pronto", 32'(pronto), 32'(exp_p));
    @(posedge clock); #1;
    m_lfsr = lfsr_step(m_lfsr, e);
  endtask

  task automatic apply_reset(input int n);
    rst_global = 1'b1; gera = 1'b0; entropia = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    rst_global = 1'b0;
    m_lfsr = SEED;
  endtask

  task automatic issue(input logic [15:0] ent, input bit chk_states);
    logic [9:0] w;
    int lat, lb, nl, nv, t, ed;
    bit lf, vf;
    model_draw(m_lfsr, ent, w, lat, lb, nl, nv, lf, vf);
    t = cyc;
    exp_q.push_back({16'(t), 16'(t + lat), w});
    step(1'b1, ent[0], -1, -1);
    for (int k = 1; k <= lat; k++) begin
      if (k <= nl) ed = 1;
      else if (k <= nl + nv) ed = 2;
      else if (k == lat - 1) ed = 3;
      else ed = 4;
      step(1'($urandom_range(0, 1)), ent[k], chk_states ? ed : -1, -1);
    end
  endtask

  task automatic request(input int gap);
    for (int i = 0; i < gap; i++) step(1'b0, 1'($urandom_range(0, 1)), -1, -1);
    issue(16'($urandom), 1'b0);
  endtask

  // Searches entropy that forces four failed attempts on the chosen draw.
  task automatic fold_request(input bit want_vid);
    logic [15:0] ent, cand;
    logic [9:0]  w;
    int lat, lb, nl, nv;
    bit lf, vf, found;
    found = 1'b0; ent = 16'h0;
    for (int tries = 0; tries < 300 && !found; tries++) begin
      for (int j = 0; j < 3000 && !found; j++) begin
        cand = 16'($urandom);
        model_draw(m_lfsr, cand, w, lat, lb, nl, nv, lf, vf);
        if (want_vid ? vf : lf) begin found = 1'b1; ent = cand; end
      end
      if (!found) step(1'b0, 1'($urandom_range(0, 1)), -1, -1);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL fold_search: got no entropy pattern, expected one for %s fold", want_vid ? "seer" : "wolf");
    end else begin
      issue(ent, 1'b1);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [41:0] m_e;
  int m_n01, m_n10, m_n11, m_lobo_pos;

  always @(negedge clock) begin
    if (!rst_global) begin
      if (pronto) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pronto: got pronto=1, expected 0 (cycle %0d, jogo 0x%0h)", cyc, jogo);
        end else begin
          m_e = exp_q.pop_front();
          check("jogo", 32'(jogo), 32'(m_e[9:0]));
          check("pronto_cycle", 32'(cyc), 32'(m_e[25:10]));
          check("latency_range", ((cyc - int'(m_e[41:26])) >= 4 && (cyc - int'(m_e[41:26])) <= 10) ? 32'd1 : 32'd0, 32'd1);
          m_n01 = 0; m_n10 = 0; m_n11 = 0; m_lobo_pos = 0;
          for (int s = 0; s < 5; s++) begin
            case (jogo[2*s +: 2])
              2'b01: begin m_n01++; m_lobo_pos = s; end
              2'b10: m_n10++;
              2'b11: m_n11++;
              default: ;
            endcase
          end
          check("word_shape", 32'({m_n01[3:0], m_n10[3:0], m_n11[3:0]}), 32'h110);
          if (m_n01 == 1) seen_lobo[m_lobo_pos] = 1'b1;
          n_pronto++;
        end
      end else if (exp_q.size() > 0 && cyc > int'(exp_q[0][25:10])) begin
        m_e = exp_q.pop_front();
        tests++; fails++;
        $display("FAIL missing_pronto: got no pulse, expected one at cycle %0d", int'(m_e[25:10]));
      end
    end
  end

  // ---------------- stimulus ----------------
  int n_seen;

  initial begin
    rst_global = 1'b1; gera = 1'b0; entropia = 1'b0;

    // Deterministic draw from the reset seed: lobo=1, vidente=2.
    apply_reset(2);
    check("reset_jogo", 32'(jogo), 32'h000);
    exp_q.push_back({16'(cyc), 16'(cyc + 4), 10'h024});
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1, 0);
    step(1'b0, 1'b0, 2, 0);
    check("jogo_before_monta", 32'(jogo), 32'h000);
    step(1'b0, 1'b0, 3, 0);
    check("jogo_det", 32'(jogo), 32'h024);
    step(1'b0, 1'b0, 4, 1);
    check("jogo_hold", 32'(jogo), 32'h024);
    step(1'b0, 1'b0, 0, 0);

    // Request while busy is dropped.
    apply_reset(2);
    check("reset_jogo_2", 32'(jogo), 32'h000);
    exp_q.push_back({16'(cyc), 16'(cyc + 4), 10'h024});
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1, 0);
    step(1'b1, 1'b0, 2, 0);
    step(1'b0, 1'b0, 3, 0);
    step(1'b0, 1'b0, 4, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 0);

    // Reset in the middle of a draw.
    apply_reset(2);
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1, 0);
    rst_global = 1'b1;
    step(1'b0, 1'b0, 2, 0);
    rst_global = 1'b0;
    m_lfsr = SEED;
    check("abort_jogo", 32'(jogo), 32'h000);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0, 0);

    // Randomised sweep.
    for (int r = 0; r < 200; r++) request($urandom_range(0, 3));

    // Forced fold paths with the state sequence checked every cycle.
    for (int r = 0; r < 3; r++) begin
      fold_request(1'b0);
      fold_request(1'b1);
    end

    for (int i = 0; i < 15; i++) step(1'b0, 1'($urandom_range(0, 1)), -1, -1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("pronto_count", 32'(n_pronto), 32'd208);
    n_seen = 0;
    for (int s = 0; s < 5; s++) if (seen_lobo[s]) n_seen++;
    check("lobo_coverage", 32'(n_seen), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gerador_jogo.md
# gerador_jogo

Encoder for the game-word format consumed by the class decoder. On request it draws one werewolf and one seer position among 5 players and packs them into a 10-bit `jogo` word. The word can be loaded into the game register as an alternative to the seed ROM. The draw comes from an 8-bit LFSR that is perturbed by user entropy, and the block signals completion with a one-cycle `pronto` pulse.

## Interface

Parameters:
- `SEMENTE`, default 8'hB4: LFSR value loaded on reset. Must be nonzero.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `rst_global`  in  1  reset; synchronous and active-high.
- `gera`  in  1  request a new game. Sampled only in IDLE.
- `entropia`  in  1  entropy bit, XORed into the LFSR feedback every cycle (e.g. the raw button level).
- `jogo`  out  10  packed game word. Player i occupies bits [2i+1:2i], player 0 in [1:0].
- `pronto`  out  1  one-cycle pulse; `jogo` is valid and new while it is high.
- `ocupado`  out  1  high in every state except IDLE.
- `db_estado`  out  3  state encoding for debug: IDLE=0, SORTEIA_LOBO=1, SORTEIA_VIDENTE=2, MONTA=3, PRONTO=4.

## Operation

- Class codes:
  - 00 aldeão
  - 01 lobisomem
  - 10 vidente
  - 11 reserved; never produced.
- LFSR:
  - 8-bit; advances on every clock edge regardless of state.
  - Next value is `{lfsr[6:0], fb}`, where fb = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]^entropia.
  - If that next value would be 8'h00, load 8'h01 instead.
- Candidate: `c = lfsr[2:0]`, taken from the current register value.
- Attempt counter `tent`: 2 bits; cleared on entry to each SORTEIA_* state.
- IDLE:
  - `gera`=1 → SORTEIA_LOBO.
  - Otherwise stay.
- SORTEIA_LOBO:
  - If c<5: `lobo`<=c, go to SORTEIA_VIDENTE.
  - Else if `tent`=3: `lobo`<=c-5, go to SORTEIA_VIDENTE.
  - Else: `tent`++, stay.
- SORTEIA_VIDENTE:
  - Valid if c<5 and c≠`lobo`; then `vidente`<=c, go to MONTA.
  - Invalid and `tent`<3: `tent`++, stay.
  - Invalid and `tent`=3 (fold):
    - Let v = (c≥5) ? c-5 : c.
    - If v=`lobo`, use (lobo+1) mod 5; else use v.
    - Go to MONTA.
- MONTA:
  - `jogo` <= word with 01 at slot `lobo`, 10 at slot `vidente`, 00 elsewhere.
  - Go to PRONTO.
- PRONTO:
  - `pronto`=1.
  - Go to IDLE.
- `jogo` holds its value until the next MONTA.
- Every word produced contains exactly one 01, exactly one 10 and three 00.

## Timing

- Reset values:
  - state IDLE
  - `lfsr`=SEMENTE
  - `jogo`=10'h000
  - `pronto`=0, `ocupado`=0, `db_estado`=0
  - `lobo`=0, `vidente`=0, `tent`=0
- Latency, with `gera` sampled at the edge ending cycle t:
  - Minimum: `pronto` high in cycle t+4.
  - Maximum: t+10 (4 attempts for each draw).
- `jogo` changes at the edge ending MONTA. It is therefore stable during and after `pronto`.
- `gera` while `ocupado`=1 is ignored; no queueing and no restart.
- `gera` held high continuously → back-to-back draws. A new draw starts one cycle after `pronto` (the IDLE cycle samples it).
- `rst_global` mid-draw:
  - Aborts the draw and applies all reset values on that edge.
  - No `pronto` is emitted.
- `rst_global` has priority over `gera` in the same cycle.
- `entropia` is unsynchronised user input. It only affects the LFSR value, so metastability is tolerated by design; no other path depends on it.

## Test plan

- Reset: hold `rst_global` 2 cycles → `jogo`=10'h000, `pronto`=0, `ocupado`=0, `db_estado`=0.
- Deterministic draw:
  - Setup: SEMENTE=8'hB4, `entropia`=0; release reset, then pulse `gera` in the first cycle c0.
  - LFSR sequence: 8'h69 in c1 (lobo=1), 8'hD2 in c2 (vidente=2).
  - Required: `pronto`=1 in c4, `jogo`=10'h024, `ocupado` high c1..c4.
- Busy ignore: repeat the deterministic draw with an extra `gera` pulse in c2 → exactly one `pronto` (c4), `jogo`=10'h024, `db_estado`=0 in c5.
- Reset mid-draw: assert `rst_global` in c2 of the deterministic draw → `db_estado`=0 and `jogo`=10'h000 from c3; no `pronto`.
- Randomised sweep:
  - Stimulus: 200 requests with random `entropia` and random `gera` gaps.
  - Required per result: exactly one 01 and one 10, no 11, and `pronto` between t+4 and t+10.
  - Required overall: every lobo position 0..4 observed.
- Fold path:
  - Drive `entropia` so that c≥5 or c=`lobo` for 4 consecutive cycles.
  - Required: state leaves SORTEIA_* after exactly 4 cycles, with the value given by the fold rule.
  - Checker: an independent reference LFSR model.
